// File: rtl/uart_tx_fifo_if.sv
// ---------------------------------------------------------------------------
// uart_tx_fifo_if
// Groups the host push port, the transmitter pop port, and the status/error
// outputs of the UART transmit FIFO.
//   master : drives flush, wr_en, wr_data, rd_en; observes the status outputs
//   slave  : the FIFO itself
// Signals:
//   flush        synchronous clear of all contents
//   wr_en        push wr_data this cycle
//   wr_data      word to push
//   rd_en        pop the head word this cycle
//   rd_data      head word, first-word-fall-through, valid while !empty
//   full         count == Depth
//   almost_full  count >= AlmostFullThresh
//   empty        count == 0
//   count        occupancy, 0..Depth
//   overflow     1-cycle pulse after a rejected write
//   underflow    1-cycle pulse after a rejected read
// ---------------------------------------------------------------------------
interface uart_tx_fifo_if #(
  parameter int DataLength = 8,
  parameter int Depth      = 16
);
  localparam int CntW = $clog2(Depth) + 1;

  logic                  flush;
  logic                  wr_en;
  logic [DataLength-1:0] wr_data;
  logic                  rd_en;
  logic [DataLength-1:0] rd_data;
  logic                  full;
  logic                  almost_full;
  logic                  empty;
  logic [CntW-1:0]       count;
  logic                  overflow;
  logic                  underflow;

  modport master (
    output flush, wr_en, wr_data, rd_en,
    input  rd_data, full, almost_full, empty, count, overflow, underflow
  );

  modport slave (
    input  flush, wr_en, wr_data, rd_en,
    output rd_data, full, almost_full, empty, count, overflow, underflow
  );
endinterface

// File: rtl/uart_tx_fifo.sv
// ---------------------------------------------------------------------------
// uart_tx_fifo
// Synchronous first-word-fall-through FIFO buffering host bytes for the UART
// transmitter. The head word is visible on bus.rd_data whenever bus.empty is
// low and is popped with a single-cycle bus.rd_en pulse.
// Ports:
//   i_clk    clock (baud * oversample)
//   i_rst_n  asynchronous, active-low reset
//   bus      uart_tx_fifo_if.slave: push/pop handshakes, status and errors
// Parameters:
//   DataLength        word width in bits
//   Depth             number of entries, power of two, >= 2
//   AlmostFullThresh  almost_full asserts when count >= this value
// ---------------------------------------------------------------------------
module uart_tx_fifo #(
  parameter int DataLength       = 8,
  parameter int Depth            = 16,
  parameter int AlmostFullThresh = 12
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  uart_tx_fifo_if.slave      bus
);
  localparam int PtrW = $clog2(Depth);
  localparam int CntW = PtrW + 1;

  // Storage is deliberately not reset so it can map to distributed/block RAM.
  logic [DataLength-1:0] mem [Depth];

  logic [PtrW-1:0] wr_ptr_reg, wr_ptr_next;
  logic [PtrW-1:0] rd_ptr_reg, rd_ptr_next;
  logic [CntW-1:0] count_reg, count_next;
  logic            empty_reg, full_reg, almost_full_reg;
  logic            overflow_reg, underflow_reg;
  logic            overflow_next, underflow_next;
  logic            wr_ok, rd_ok;
  logic            mem_we;

  // A read is only accepted when something is stored. A write into a full
  // FIFO is still accepted if a pop frees the head entry in the same cycle.
  assign rd_ok  = bus.rd_en && !empty_reg;
  assign wr_ok  = bus.wr_en && (!full_reg || rd_ok);
  // Flush discards any same-cycle write, so the array is not touched.
  assign mem_we = wr_ok && !bus.flush;

  always_comb begin
    wr_ptr_next    = wr_ptr_reg;
    rd_ptr_next    = rd_ptr_reg;
    count_next     = count_reg;
    overflow_next  = 1'b0;
    underflow_next = 1'b0;
    if (bus.flush) begin
      wr_ptr_next = '0;
      rd_ptr_next = '0;
      count_next  = '0;
    end else begin
      if (wr_ok) wr_ptr_next = wr_ptr_reg + PtrW'(1);
      if (rd_ok) rd_ptr_next = rd_ptr_reg + PtrW'(1);
      case ({wr_ok, rd_ok})
        2'b10:   count_next = count_reg + CntW'(1);
        2'b01:   count_next = count_reg - CntW'(1);
        default: count_next = count_reg;
      endcase
      overflow_next  = bus.wr_en && !wr_ok;
      underflow_next = bus.rd_en && !rd_ok;
    end
  end

  // Flags are decoded from the next count so they line up with o_count.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      wr_ptr_reg      <= '0;
      rd_ptr_reg      <= '0;
      count_reg       <= '0;
      empty_reg       <= 1'b1;
      full_reg        <= 1'b0;
      almost_full_reg <= 1'b0;
      overflow_reg    <= 1'b0;
      underflow_reg   <= 1'b0;
    end else begin
      wr_ptr_reg      <= wr_ptr_next;
      rd_ptr_reg      <= rd_ptr_next;
      count_reg       <= count_next;
      empty_reg       <= (count_next == '0);
      full_reg        <= (count_next == CntW'(Depth));
      almost_full_reg <= (count_next >= CntW'(AlmostFullThresh));
      overflow_reg    <= overflow_next;
      underflow_reg   <= underflow_next;
    end
  end

  always_ff @(posedge i_clk) begin
    if (mem_we) mem[wr_ptr_reg] <= bus.wr_data;
  end

  // Combinational head read: only rd_ptr selects it, so writes landing in
  // other entries never disturb the word the transmitter is sending.
  assign bus.rd_data     = mem[rd_ptr_reg];
  assign bus.empty       = empty_reg;
  assign bus.full        = full_reg;
  assign bus.almost_full = almost_full_reg;
  assign bus.count       = count_reg;
  assign bus.overflow    = overflow_reg;
  assign bus.underflow   = underflow_reg;
endmodule
